// File: rtl/vram_pkg.sv
// Shared types for the video RAM arbiter: grant and return-tag encodings,
// plus the width helper for FIFO occupancy counters.
package vram_pkg;

  typedef enum logic [1:0] {
    GNT_IDLE = 2'd0,
    GNT_VID  = 2'd1,
    GNT_CPU  = 2'd2
  } grant_e;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_VID  = 2'd1,
    TAG_CPU  = 2'd2
  } tag_e;

  // Occupancy runs 0..depth inclusive, so it needs one value more than a pointer.
  function automatic int level_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/vram_arbiter_if.sv
// Bus bundle between the arbiter, its CPU/video clients and the frame-buffer RAM.
// The slave modport is the arbiter's view; master is the surrounding system.
interface vram_arbiter_if #(
  parameter int ADDR_WIDTH = 19,
  parameter int DATA_WIDTH = 9
);
  logic                  i_frame_start;
  logic                  i_vid_pop;
  logic [DATA_WIDTH-1:0] o_vid_data;
  logic                  o_vid_empty;
  logic                  o_underflow;
  logic                  i_cpu_valid;
  logic                  o_cpu_ready;
  logic                  i_cpu_we;
  logic [ADDR_WIDTH-1:0] i_cpu_addr;
  logic [DATA_WIDTH-1:0] i_cpu_wdata;
  logic                  o_cpu_rvalid;
  logic [DATA_WIDTH-1:0] o_cpu_rdata;
  logic                  o_ram_en;
  logic                  o_ram_we;
  logic [ADDR_WIDTH-1:0] o_ram_addr;
  logic [DATA_WIDTH-1:0] o_ram_wdata;
  logic [DATA_WIDTH-1:0] i_ram_rdata;

  modport slave (
    input  i_frame_start, i_vid_pop, i_cpu_valid, i_cpu_we, i_cpu_addr,
           i_cpu_wdata, i_ram_rdata,
    output o_vid_data, o_vid_empty, o_underflow, o_cpu_ready, o_cpu_rvalid,
           o_cpu_rdata, o_ram_en, o_ram_we, o_ram_addr, o_ram_wdata
  );

  modport master (
    output i_frame_start, i_vid_pop, i_cpu_valid, i_cpu_we, i_cpu_addr,
           i_cpu_wdata, i_ram_rdata,
    input  o_vid_data, o_vid_empty, o_underflow, o_cpu_ready, o_cpu_rvalid,
           o_cpu_rdata, o_ram_en, o_ram_we, o_ram_addr, o_ram_wdata
  );
endinterface

// File: rtl/vram_fifo.sv
// Prefetch FIFO with flush and a registered head word. The head register holds
// the oldest entry; mem_q holds the entries behind it.
module vram_fifo
  import vram_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 9,
  parameter int CNT_W = level_width(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] head_q, head_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic             mem_we;
  logic             pop_ok;

  // NOTE: every signal gets a default before any branch, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    head_d   = head_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    mem_we   = 1'b0;
    pop_ok   = 1'b0;
    if (i_flush) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      pop_ok = i_pop && (count_q != '0);
      // A push into an empty (or emptying) FIFO goes straight to the head.
      if (i_push && ((count_q == '0) || ((count_q == CNT_W'(1)) && pop_ok))) begin
        head_d = i_wdata;
      end else if (i_push) begin
        mem_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok && (count_q > CNT_W'(1))) begin
        head_d   = mem_q[rd_ptr_q];
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(i_push) - CNT_W'(pop_ok);
    end
  end

  // NOTE: state uses non-blocking assignments so all flops update together from pre-edge values.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      head_q   <= '0;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      head_q   <= head_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // NOTE: storage is not reset; count and pointers alone define which words are valid.
  always_ff @(posedge i_clk) begin
    if (mem_we) mem_q[wr_ptr_q] <= i_wdata;
  end

  assign o_rdata = head_q;
  assign o_empty = (count_q == '0);
  assign o_count = count_q;

endmodule

// File: rtl/vram_arbiter.sv
// Shares a single-port video RAM between a sequential scan-out prefetch and
// CPU reads/writes; video wins outright only when its buffer runs low.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int ADDR_WIDTH  = 19,
  parameter int DATA_WIDTH  = 9,
  parameter int FB_BASE     = 0,
  parameter int FRAME_WORDS = 307200,
  parameter int FIFO_DEPTH  = 16,
  parameter int LOW_WATER   = 4
) (
  input logic           i_clk,
  input logic           i_reset,
  vram_arbiter_if.slave bus
);
  localparam int LVL_W = level_width(FIFO_DEPTH);
  localparam int REM_W = $clog2(FRAME_WORDS + 1);

  grant_e                grant;
  tag_e                  tag_q, tag_d;
  logic [ADDR_WIDTH-1:0] fetch_addr_q, fetch_addr_d;
  logic [REM_W-1:0]      remaining_q, remaining_d;
  logic                  underflow_q, underflow_d;
  logic [LVL_W-1:0]      fifo_count;
  logic [LVL_W-1:0]      level;
  logic                  vid_left, vid_room, fifo_empty;

  vram_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_WIDTH), .CNT_W(LVL_W)) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_flush (bus.i_frame_start),
    .i_push  ((tag_q == TAG_VID) && !bus.i_frame_start),
    .i_wdata (bus.i_ram_rdata),
    .i_pop   (bus.i_vid_pop),
    .o_rdata (bus.o_vid_data),
    .o_empty (fifo_empty),
    .o_count (fifo_count)
  );

  // The in-flight video read is counted so a push can never overflow.
  assign level    = fifo_count + LVL_W'(tag_q == TAG_VID);
  assign vid_left = (remaining_q != '0);
  assign vid_room = (level < LVL_W'(FIFO_DEPTH));

  always_comb begin
    grant        = GNT_IDLE;
    tag_d        = TAG_NONE;
    fetch_addr_d = fetch_addr_q;
    remaining_d  = remaining_q;
    underflow_d  = underflow_q;

    if (bus.i_frame_start)                                grant = GNT_IDLE;
    else if (vid_left && (level < LVL_W'(LOW_WATER)))     grant = GNT_VID;
    else if (bus.i_cpu_valid)                             grant = GNT_CPU;
    else if (vid_left && vid_room)                        grant = GNT_VID;

    if (grant == GNT_VID) begin
      tag_d        = TAG_VID;
      fetch_addr_d = fetch_addr_q + ADDR_WIDTH'(1);
      remaining_d  = remaining_q - REM_W'(1);
    end else if ((grant == GNT_CPU) && !bus.i_cpu_we) begin
      tag_d = TAG_CPU;
    end

    if (bus.i_frame_start) begin
      fetch_addr_d = ADDR_WIDTH'(FB_BASE);
      remaining_d  = REM_W'(FRAME_WORDS);
      underflow_d  = 1'b0;
    end else if (bus.i_vid_pop && fifo_empty) begin
      underflow_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      tag_q        <= TAG_NONE;
      fetch_addr_q <= ADDR_WIDTH'(FB_BASE);
      remaining_q  <= '0;
      underflow_q  <= 1'b0;
    end else begin
      tag_q        <= tag_d;
      fetch_addr_q <= fetch_addr_d;
      remaining_q  <= remaining_d;
      underflow_q  <= underflow_d;
    end
  end

  assign bus.o_cpu_ready  = (grant == GNT_CPU);
  assign bus.o_ram_en     = (grant != GNT_IDLE);
  assign bus.o_ram_we     = (grant == GNT_CPU) && bus.i_cpu_we;
  assign bus.o_ram_addr   = (grant == GNT_VID) ? fetch_addr_q :
                            (grant == GNT_CPU) ? bus.i_cpu_addr : '0;
  assign bus.o_ram_wdata  = (grant == GNT_CPU) ? bus.i_cpu_wdata : '0;
  assign bus.o_cpu_rvalid = (tag_q == TAG_CPU);
  assign bus.o_cpu_rdata  = (tag_q == TAG_CPU) ? bus.i_ram_rdata : '0;
  assign bus.o_vid_empty  = fifo_empty;
  assign bus.o_underflow  = underflow_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: reset, cold fill, CPU under load, low-water
// priority, frame restart, underflow and end-of-frame on a short-frame instance.
module tb_vram_arbiter;
  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  vram_arbiter_if #(.ADDR_WIDTH(19), .DATA_WIDTH(9)) b1 ();
  vram_arbiter_if #(.ADDR_WIDTH(19), .DATA_WIDTH(9)) b2 ();

  vram_arbiter dut1 (.i_clk(clk), .i_reset(rst_n), .bus(b1));
  vram_arbiter #(.FRAME_WORDS(20)) dut2 (.i_clk(clk), .i_reset(rst_n), .bus(b2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [8:0] word(input int a);
    return 9'((a * 37 + 5) % 512);
  endfunction

  logic [8:0] ram [0:1023];
  initial for (int i = 0; i < 1024; i++) ram[i] = word(i);

  always @(posedge clk) begin
    if (b1.o_ram_en) begin
      if (b1.o_ram_we) ram[b1.o_ram_addr[9:0]] <= b1.o_ram_wdata;
      else             b1.i_ram_rdata <= ram[b1.o_ram_addr[9:0]];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    int cnt;
    rst_n = 1'b0;
    b1.i_frame_start = 0; b1.i_vid_pop = 0; b1.i_cpu_valid = 0; b1.i_cpu_we = 0;
    b1.i_cpu_addr = '0; b1.i_cpu_wdata = '0;
    b2.i_frame_start = 0; b2.i_vid_pop = 0; b2.i_cpu_valid = 0; b2.i_cpu_we = 0;
    b2.i_cpu_addr = '0; b2.i_cpu_wdata = '0; b2.i_ram_rdata = '0;

    // Reset held for three edges
    repeat (3) @(posedge clk);
    smp();
    check("rst_ram_en", b1.o_ram_en, 0);
    check("rst_ram_we", b1.o_ram_we, 0);
    check("rst_ram_addr", b1.o_ram_addr, 0);
    check("rst_cpu_ready", b1.o_cpu_ready, 0);
    check("rst_rvalid", b1.o_cpu_rvalid, 0);
    check("rst_rdata", b1.o_cpu_rdata, 0);
    check("rst_vid_data", b1.o_vid_data, 0);
    check("rst_vid_empty", b1.o_vid_empty, 1);
    check("rst_underflow", b1.o_underflow, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      nxt(); smp();
      check("idle_no_fetch", b1.o_ram_en, 0);
    end

    // Cold fill: 16 sequential reads, then idle with a full FIFO
    nxt(); b1.i_frame_start = 1;
    smp(); check("fs_no_grant", b1.o_ram_en, 0);
    nxt(); b1.i_frame_start = 0;
    for (int k = 0; k < 16; k++) begin
      smp();
      check("fill_en", b1.o_ram_en, 1);
      check("fill_addr", b1.o_ram_addr, k);
      if (k == 1) check("fill_empty_n1", b1.o_vid_empty, 1);
      if (k == 2) check("fill_head_n2", b1.o_vid_data, word(0));
      nxt();
    end
    smp();
    check("full_idle", b1.o_ram_en, 0);
    check("full_head", b1.o_vid_data, word(0));

    // Pop six words while the CPU streams reads, one per cycle
    for (int i = 0; i < 6; i++) begin
      nxt();
      b1.i_vid_pop = 1; b1.i_cpu_valid = 1; b1.i_cpu_we = 0; b1.i_cpu_addr = 19'(32'h200 + i);
      smp();
      check("popB_data", b1.o_vid_data, word(i));
      check("cpuB_ready", b1.o_cpu_ready, 1);
      check("cpuB_addr", b1.o_ram_addr, 32'h200 + i);
      if (i > 0) begin
        check("cpuB_rvalid", b1.o_cpu_rvalid, 1);
        check("cpuB_rdata", b1.o_cpu_rdata, word(32'h200 + i - 1));
      end
    end

    // CPU write then read-back of 0x100 with FIFO at 10
    nxt(); b1.i_vid_pop = 0; b1.i_cpu_we = 1; b1.i_cpu_addr = 19'h100; b1.i_cpu_wdata = 9'h1AB;
    smp();
    check("wr_prev_rvalid", b1.o_cpu_rvalid, 1);
    check("wr_prev_rdata", b1.o_cpu_rdata, word(32'h205));
    check("wr_ready", b1.o_cpu_ready, 1);
    check("wr_ram_we", b1.o_ram_we, 1);
    check("wr_ram_addr", b1.o_ram_addr, 32'h100);
    check("wr_ram_wdata", b1.o_ram_wdata, 32'h1AB);
    nxt(); b1.i_cpu_we = 0;
    smp();
    check("rd_ready", b1.o_cpu_ready, 1);
    check("rd_ram_we", b1.o_ram_we, 0);
    check("wr_no_rvalid", b1.o_cpu_rvalid, 0);
    nxt(); b1.i_cpu_valid = 0;
    smp();
    check("rd_rvalid", b1.o_cpu_rvalid, 1);
    check("rd_rdata", b1.o_cpu_rdata, 32'h1AB);
    check("refill_addr", b1.o_ram_addr, 16);

    // Drain with CPU held until level drops below low water
    for (int i = 0; i < 8; i++) begin
      nxt(); b1.i_vid_pop = 1; b1.i_cpu_valid = 1; b1.i_cpu_addr = 19'(32'h300 + i);
      smp();
      check("drain_ready", b1.o_cpu_ready, 1);
      check("drain_data", b1.o_vid_data, word(6 + i));
    end
    nxt(); b1.i_vid_pop = 0; b1.i_cpu_addr = 19'h210;
    smp();
    check("lw_ready", b1.o_cpu_ready, 0);
    check("lw_vid_en", b1.o_ram_en, 1);
    check("lw_vid_addr", b1.o_ram_addr, 17);
    nxt(); smp();
    check("lw_cpu_back", b1.o_cpu_ready, 1);
    check("lw_cpu_addr", b1.o_ram_addr, 32'h210);
    nxt(); b1.i_cpu_valid = 0;
    smp();
    check("lw_rdata", b1.o_cpu_rdata, word(32'h210));
    check("vid_issue_addr", b1.o_ram_addr, 18);

    // Frame restart with a video read in flight and a CPU request waiting
    nxt(); b1.i_frame_start = 1; b1.i_cpu_valid = 1; b1.i_cpu_addr = 19'h220;
    smp();
    check("rs_no_grant", b1.o_ram_en, 0);
    check("rs_ready", b1.o_cpu_ready, 0);
    nxt(); b1.i_frame_start = 0;
    smp();
    check("rs_empty", b1.o_vid_empty, 1);
    check("rs_addr0", b1.o_ram_addr, 0);
    check("rs_ready0", b1.o_cpu_ready, 0);
    nxt(); smp();
    check("rs_empty1", b1.o_vid_empty, 1);
    check("rs_addr1", b1.o_ram_addr, 1);
    nxt(); smp();
    check("rs_head", b1.o_vid_data, word(0));
    check("rs_addr2", b1.o_ram_addr, 2);
    check("rs_ready2", b1.o_cpu_ready, 0);
    nxt(); smp();
    check("rs_addr3", b1.o_ram_addr, 3);
    check("rs_ready3", b1.o_cpu_ready, 0);
    nxt(); smp();
    check("rs_cpu_ready", b1.o_cpu_ready, 1);
    check("rs_cpu_addr", b1.o_ram_addr, 32'h220);
    nxt(); b1.i_cpu_addr = 19'h230;
    smp();
    check("rs_cpu_rdata", b1.o_cpu_rdata, word(32'h220));
    check("rs_cpu_ready2", b1.o_cpu_ready, 1);
    nxt(); b1.i_cpu_valid = 0; b1.i_frame_start = 1;
    smp();
    check("fs_cpu_rvalid", b1.o_cpu_rvalid, 1);
    check("fs_cpu_rdata", b1.o_cpu_rdata, word(32'h230));
    check("fs_en", b1.o_ram_en, 0);

    // Pop while empty sets sticky underflow; next frame start clears it
    nxt(); b1.i_frame_start = 0; b1.i_vid_pop = 1;
    smp();
    check("uf_empty", b1.o_vid_empty, 1);
    check("uf_addr0", b1.o_ram_addr, 0);
    check("uf_rvalid0", b1.o_cpu_rvalid, 0);
    check("uf_clear", b1.o_underflow, 0);
    nxt(); b1.i_vid_pop = 0;
    smp(); check("uf_set", b1.o_underflow, 1);
    nxt(); smp();
    check("uf_sticky", b1.o_underflow, 1);
    check("uf_head_intact", b1.o_vid_data, word(0));
    nxt(); b1.i_frame_start = 1;
    smp(); check("uf_hold_fs", b1.o_underflow, 1);
    nxt(); b1.i_frame_start = 0;
    smp(); check("uf_cleared", b1.o_underflow, 0);

    // Short frame: exactly 20 video reads, then none
    nxt(); b2.i_frame_start = 1; b2.i_vid_pop = 1;
    nxt(); b2.i_frame_start = 0;
    cnt = 0;
    for (int c = 0; c < 80; c++) begin
      smp();
      if (b2.o_ram_en) begin
        check("eof_addr", b2.o_ram_addr, cnt);
        cnt++;
      end
      nxt();
    end
    smp();
    check("eof_count", cnt, 20);
    check("eof_idle", b2.o_ram_en, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Arbitrates one single-port synchronous video RAM between the scan-out path and the CPU bus. A fetch engine streams pixel words sequentially from `FB_BASE` into an internal prefetch FIFO, which the pixel pipeline pops once per active pixel. CPU reads and writes are granted into the remaining RAM slots. The block sits between the VGA timing/pattern logic in `Top` and the frame-buffer RAM.

## Interface
- `ADDR_WIDTH`, 19: RAM word address width.
- `DATA_WIDTH`, 9: word width; one pixel per word, 3×`SUB_PIXEL_WIDTH`.
- `FB_BASE`, 0: first word address of the frame.
- `FRAME_WORDS`, 307200: words fetched per frame (640×480).
- `FIFO_DEPTH`, 16: prefetch FIFO depth; must be a power of 2 and ≥4.
- `LOW_WATER`, 4: video level below which video has absolute priority.

Ports:
- `i_clk` in 1: clock.
- `i_reset` in 1: synchronous, active-low reset.
- `i_frame_start` in 1: one-cycle pulse during vblank; restarts the frame fetch.
- `i_vid_pop` in 1: pixel pipeline consumes the FIFO head this cycle.
- `o_vid_data` out DATA_WIDTH: FIFO head, valid when `!o_vid_empty`.
- `o_vid_empty` out 1: FIFO empty.
- `o_underflow` out 1: sticky; set on a pop while empty, cleared only by `i_frame_start` or reset.
- `i_cpu_valid` in 1, `o_cpu_ready` out 1: request handshake.
- `i_cpu_we` in 1, `i_cpu_addr` in ADDR_WIDTH, `i_cpu_wdata` in DATA_WIDTH: CPU request fields.
- `o_cpu_rvalid` out 1, `o_cpu_rdata` out DATA_WIDTH: read response.
- `o_ram_en` out 1, `o_ram_we` out 1, `o_ram_addr` out ADDR_WIDTH, `o_ram_wdata` out DATA_WIDTH: RAM command.
- `i_ram_rdata` in DATA_WIDTH: RAM read data, valid 1 cycle after a read command.

## Operation
- `level` is FIFO occupancy plus the video read in flight (0/1). Its width is `$clog2(FIFO_DEPTH+1)`.
- `vid_room` is `level < FIFO_DEPTH`.
- `vid_left` is `remaining != 0`. `remaining` is loaded with `FRAME_WORDS` on `i_frame_start` and decremented on each video grant.
- Grant per cycle, evaluated in priority order. `i_frame_start` overrides all of it: no grant that cycle.
  1. VID if `vid_left && level < LOW_WATER`.
  2. CPU if `i_cpu_valid`.
  3. VID if `vid_left && vid_room`.
  4. IDLE otherwise.
- `o_cpu_ready` is high exactly when the grant is CPU. It may depend combinationally on `i_cpu_valid`. A transfer occurs when `valid && ready`. Request fields must stay stable while `valid && !ready`.
- RAM command outputs are combinational from the grant in the same cycle.
  - VID grant: read at `fetch_addr`, then `fetch_addr++`.
  - CPU grant: `o_ram_we = i_cpu_we`, address and data passed through.
- A registered tag (NONE/VID/CPU) marks the returning read.
  - VID tag: `i_ram_rdata` is pushed into the FIFO.
  - CPU tag: `o_cpu_rvalid = 1`, `o_cpu_rdata = i_ram_rdata`.
  - CPU writes produce no response.
- `i_frame_start`:
  - flushes the FIFO and clears `o_underflow`;
  - sets `fetch_addr = FB_BASE` and `remaining = FRAME_WORDS`;
  - converts a pending VID tag to NONE, so stale data is dropped;
  - leaves a pending CPU tag and its response untouched.
- Pop while empty: no state change except setting `o_underflow`.
- Push and pop in the same cycle: occupancy is unchanged.
- Push never overflows, because `level` already counts the in-flight read.

## Timing
- Reset values: all outputs 0, `o_vid_empty = 1`, FIFO empty, tag NONE, `fetch_addr = FB_BASE`, `remaining = 0`. No fetch happens until the first `i_frame_start`.
- CPU read latency: accept in cycle N, `o_cpu_rvalid` in N+1, for exactly one cycle.
- Video latency: VID grant in N, word visible at the FIFO head by N+2 if the FIFO was empty.
- The FIFO head output is registered.
- CPU throughput: 1 per cycle while `level ≥ LOW_WATER`.
- Guaranteed CPU share: no lower bound while video is below `LOW_WATER`. The CPU can stall for at most `LOW_WATER` cycles after pops stop.

## Structure
- Package `vram_pkg`:
  - `grant_e` (IDLE, VID, CPU);
  - `tag_e` (NONE, VID, CPU);
  - helper constant for the `level` width.
- Sub-module `vram_fifo`: synchronous FIFO with flush, count output and registered head; parameters DEPTH and WIDTH.
- Arbitration, tag pipeline and fetch counters live in `vram_arbiter`.

## Test plan
- **Reset:** hold `i_reset = 0` for 3 cycles → all outputs 0, `o_vid_empty = 1`; no `o_ram_en` afterwards without `i_frame_start`.
- **Cold fill:** pulse `i_frame_start` with no CPU traffic → reads at 0,1,2,…,15 on consecutive cycles, then `o_ram_en = 0` with FIFO full. `o_vid_data` follows the RAM model contents in order.
- **CPU under load:** FIFO at 10, CPU write to 0x100 with data 0x1AB → `o_cpu_ready` in the same cycle and the RAM is written. A following read of 0x100 gives `o_cpu_rvalid` with 0x1AB one cycle later.
- **Low-water priority:** level 3 with `i_cpu_valid` held → VID grant, `o_cpu_ready = 0`. CPU is accepted on the first cycle with `level ≥ 4`.
- **Frame restart mid-flight:** `i_frame_start` in the cycle after a VID read is issued with a CPU read pending → FIFO empty, stale word dropped, CPU rvalid still delivered, next video read at `FB_BASE`.
- **Underflow and end of frame:** pop while empty → `o_underflow = 1` until the next `i_frame_start`. With `FRAME_WORDS = 20`, exactly 20 video reads are issued, then none.
